// File: rtl/multimemory_pkg.sv
// Shared constants and helpers for the banked multi-port memory.
// Slots 0..REQUESTERS-1 are read ports. The following REQUESTERS slots are write ports.
package multimemory_pkg;

   localparam int DEF_REQUESTERS   = 3;
   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_BANKS        = 4;
   localparam int DEF_READ_LATENCY = 1;

   function automatic int BANK_BITS(input int banks);
      return (banks <= 1) ? 0 : $clog2(banks);
   endfunction

   // A single-row bank still needs a 1-bit row field so that port widths stay legal.
   function automatic int ROW_BITS(input int addr_w, input int banks);
      int rb;
      rb = addr_w - BANK_BITS(banks);
      return (rb > 0) ? rb : 1;
   endfunction

   function automatic int rd_slot(input int port);
      return port;
   endfunction

   function automatic int wr_slot(input int requesters, input int port);
      return requesters + port;
   endfunction

   function automatic logic is_wr_slot(input int requesters, input int slot);
      return (slot >= requesters);
   endfunction

endpackage

// File: rtl/multimemory_bank.sv
// One single-port storage bank. It contains a round-robin arbiter over every read and write slot.
// The read data register is the first stage of the read-return pipeline.
module multimemory_bank
   import multimemory_pkg::*;
#(
   parameter int REQUESTERS = DEF_REQUESTERS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int BANKS      = DEF_BANKS,
   localparam int SLOTS     = 2 * REQUESTERS,
   localparam int ROW_W     = ROW_BITS(ADDR_WIDTH, BANKS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [SLOTS-1:0]                 req_i,
   input  logic [SLOTS*ROW_W-1:0]           row_i,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] wdata_i,
   output logic [SLOTS-1:0]                 gnt_o,
   output logic [DATA_WIDTH-1:0]            rdata_o
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH - BANK_BITS(BANKS));
   localparam int PTR_W = $clog2(SLOTS);

   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  found;
   int                    win;
   int                    idx;
   int                    wr_idx;
   logic                  win_is_wr;
   logic [ROW_W-1:0]      win_row;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] memory [DEPTH];

   // The search starts at ptr and wraps around. Reset masks every request, so nothing is granted or written.
   always_comb begin
      found     = 1'b0;
      win       = 0;
      idx       = 0;
      gnt_o     = '0;
      ptr_d     = ptr_q;
      for (int off = 0; off < SLOTS; off++) begin
         idx = (int'(ptr_q) + off) % SLOTS;
         if (!found && !rst && req_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (found) begin
         gnt_o[win] = 1'b1;
         ptr_d      = (win == SLOTS - 1) ? '0 : PTR_W'(win + 1);
      end
      win_is_wr = is_wr_slot(REQUESTERS, win);
      wr_idx    = win_is_wr ? (win - REQUESTERS) : 0;
      win_row   = row_i[win*ROW_W +: ROW_W];
      win_wdata = wdata_i[wr_idx*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (found) begin
         if (win_is_wr) begin
            memory[win_row] <= win_wdata;
         end else begin
            rdata_q <= memory[win_row];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/multimemory_banked.sv
// A multi-port memory with low-order address interleaving across BANKS. Each bank has its own round-robin arbiter.
// Read data returns through a fixed-latency pipeline on each port.
module multimemory_banked
   import multimemory_pkg::*;
#(
   parameter int REQUESTERS   = DEF_REQUESTERS,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int BANKS        = DEF_BANKS,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [REQUESTERS*ADDR_WIDTH-1:0] r_addr,
   input  logic [REQUESTERS-1:0]            r_avalid,
   output logic [REQUESTERS-1:0]            r_aready,
   output logic [REQUESTERS-1:0]            r_dvalid,
   output logic [REQUESTERS*DATA_WIDTH-1:0] r_data,
   input  logic [REQUESTERS*ADDR_WIDTH-1:0] w_addr,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] w_data,
   input  logic [REQUESTERS-1:0]            w_valid,
   output logic [REQUESTERS-1:0]            w_ready
);

   localparam int SLOTS  = 2 * REQUESTERS;
   localparam int BB     = BANK_BITS(BANKS);
   localparam int ROW_W  = ROW_BITS(ADDR_WIDTH, BANKS);
   localparam int BSEL_W = (BB > 0) ? BB : 1;

   logic [ADDR_WIDTH-1:0] slot_addr  [SLOTS];
   logic [BSEL_W-1:0]     slot_bank  [SLOTS];
   logic [SLOTS-1:0]      slot_valid;
   logic [SLOTS*ROW_W-1:0] slot_row;
   logic [SLOTS-1:0]      slot_gnt;
   logic [SLOTS-1:0]      bank_req   [BANKS];
   logic [SLOTS-1:0]      bank_gnt   [BANKS];
   logic [DATA_WIDTH-1:0] bank_rdata [BANKS];

   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < REQUESTERS) begin : g_rd_slot
         assign slot_addr[gi]  = r_addr[rd_slot(gi)*ADDR_WIDTH +: ADDR_WIDTH];
         assign slot_valid[gi] = r_avalid[rd_slot(gi)];
      end else begin : g_wr_slot
         assign slot_addr[gi]  = w_addr[(gi-REQUESTERS)*ADDR_WIDTH +: ADDR_WIDTH];
         assign slot_valid[gi] = w_valid[gi-REQUESTERS];
      end
      if (BB > 0) begin : g_bsel
         assign slot_bank[gi] = slot_addr[gi][BSEL_W-1:0];
      end else begin : g_bsel_none
         assign slot_bank[gi] = '0;
      end
      assign slot_row[gi*ROW_W +: ROW_W] = ROW_W'(slot_addr[gi] >> BB);
   end

   for (genvar gi = 0; gi < BANKS; gi++) begin : bank
      for (genvar gs = 0; gs < SLOTS; gs++) begin : g_req
         assign bank_req[gi][gs] = slot_valid[gs] && (slot_bank[gs] == BSEL_W'(gi));
      end

      multimemory_bank #(
         .REQUESTERS (REQUESTERS),
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .BANKS      (BANKS)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .req_i   (bank_req[gi]),
         .row_i   (slot_row),
         .wdata_i (w_data),
         .gnt_o   (bank_gnt[gi]),
         .rdata_o (bank_rdata[gi])
      );
   end

   // Each slot addresses exactly one bank, so the grants from all banks can be ORed into one vector.
   always_comb begin
      slot_gnt = '0;
      for (int b = 0; b < BANKS; b++) begin
         slot_gnt = slot_gnt | bank_gnt[b];
      end
   end

   assign r_aready = slot_gnt[REQUESTERS-1:0];
   assign w_ready  = slot_gnt[SLOTS-1:REQUESTERS];

   for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_rd
      logic                  rv_q;
      logic [BSEL_W-1:0]     rbank_q;
      logic [DATA_WIDTH-1:0] d0;
      logic                  fin_v;
      logic [DATA_WIDTH-1:0] fin_d;
      logic [DATA_WIDTH-1:0] hold_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rv_q <= 1'b0;
         end else begin
            rv_q <= r_aready[gi];
         end
      end

      always_ff @(posedge clk) begin
         rbank_q <= slot_bank[gi];
      end

      // The bank's read register holds stage one. It is only valid in the cycle after the handshake.
      assign d0 = bank_rdata[rbank_q];

      if (READ_LATENCY > 1) begin : g_pipe
         logic                  pv_q [READ_LATENCY-1];
         logic [DATA_WIDTH-1:0] pd_q [READ_LATENCY-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < READ_LATENCY - 1; s++) begin
                  pv_q[s] <= 1'b0;
                  pd_q[s] <= '0;
               end
            end else begin
               pv_q[0] <= rv_q;
               pd_q[0] <= d0;
               for (int s = 1; s < READ_LATENCY - 1; s++) begin
                  pv_q[s] <= pv_q[s-1];
                  pd_q[s] <= pd_q[s-1];
               end
            end
         end

         assign fin_v = pv_q[READ_LATENCY-2];
         assign fin_d = pd_q[READ_LATENCY-2];
      end else begin : g_direct
         assign fin_v = rv_q;
         assign fin_d = d0;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            hold_q <= '0;
         end else if (fin_v) begin
            hold_q <= fin_d;
         end
      end

      assign r_dvalid[gi]                      = fin_v;
      assign r_data[gi*DATA_WIDTH +: DATA_WIDTH] = fin_v ? fin_d : hold_q;
   end

endmodule

// File: tb/tb_multimemory_banked.sv
// Self-checking bench for multimemory_banked (3 ports, 4 banks, 16-bit, latency 1).
// Read expectations go into a scoreboard queue at the handshake. They are popped when r_dvalid is seen.
module tb_multimemory_banked;

   localparam int R  = 3;
   localparam int DW = 16;
   localparam int AW = 16;
   localparam int NB = 4;
   localparam int L  = 1;

   logic            clk;
   logic            rst;
   logic [R*AW-1:0] r_addr;
   logic [R-1:0]    r_avalid;
   logic [R-1:0]    r_aready;
   logic [R-1:0]    r_dvalid;
   logic [R*DW-1:0] r_data;
   logic [R*AW-1:0] w_addr;
   logic [R*DW-1:0] w_data;
   logic [R-1:0]    w_valid;
   logic [R-1:0]    w_ready;

   typedef struct {
      int          port;
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] shadow [int];
   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;

   multimemory_banked #(
      .REQUESTERS   (R),
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .BANKS        (NB),
      .READ_LATENCY (L)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .r_addr   (r_addr),
      .r_avalid (r_avalid),
      .r_aready (r_aready),
      .r_dvalid (r_dvalid),
      .r_data   (r_data),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .w_valid  (w_valid),
      .w_ready  (w_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every word starts out holding its own address.
   for (genvar gb = 0; gb < NB; gb++) begin : g_pre
      initial begin
         for (int r = 0; r < 16384; r++) begin
            dut.bank[gb].u_bank.memory[r] = 16'(r * NB + gb);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model_rd(input int a);
      if (shadow.exists(a)) return shadow[a];
      return 16'(a);
   endfunction

   // Scoreboard monitor: it samples 2 time units after each rising edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #2;
      for (int p = 0; p < R; p++) begin
         if (r_dvalid[p] === 1'b1) begin
            int idx;
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
               if (idx < 0 && exp_q[k].port == p) idx = k;
            end
            vectors++;
            if (idx < 0) begin
               miscompares++;
               $display("FAIL rd_unexpected port %0d: got dvalid data %h at cycle %0d, required no dvalid",
                        p, r_data[p*DW +: DW], cyc);
            end else begin
               if (r_data[p*DW +: DW] !== exp_q[idx].data || cyc != exp_q[idx].due) begin
                  miscompares++;
                  $display("FAIL rd_data port %0d: got %h at cycle %0d, required %h at cycle %0d",
                           p, r_data[p*DW +: DW], cyc, exp_q[idx].data, exp_q[idx].due);
               end
               exp_q.delete(idx);
            end
         end
      end
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
         if (exp_q[k].due < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_missing port %0d: got no dvalid by cycle %0d, required data %h at cycle %0d",
                     exp_q[k].port, cyc, exp_q[k].data, exp_q[k].due);
            exp_q.delete(k);
         end
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d reads outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      r_avalid = '0;
      w_valid  = '0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst      = 1'b1;
      r_avalid = '1;
      w_valid  = '1;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({r_aready, w_ready} !== 6'b0) begin
         miscompares++;
         $display("FAIL rst_ready: got %b, required 000000", {r_aready, w_ready});
      end
      vectors++;
      if (r_dvalid !== 3'b0) begin
         miscompares++;
         $display("FAIL rst_dvalid: got %b, required 000", r_dvalid);
      end
      vectors++;
      if (r_data !== '0) begin
         miscompares++;
         $display("FAIL rst_rdata: got %h, required 0", r_data);
      end
      vectors++;
      if (dut.bank[0].u_bank.ptr_q !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_ptr0: got %0d, required 0", dut.bank[0].u_bank.ptr_q);
      end
      vectors++;
      if (dut.bank[1].u_bank.ptr_q !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_ptr1: got %0d, required 0", dut.bank[1].u_bank.ptr_q);
      end
      vectors++;
      if (dut.bank[2].u_bank.ptr_q !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_ptr2: got %0d, required 0", dut.bank[2].u_bank.ptr_q);
      end
      vectors++;
      if (dut.bank[3].u_bank.ptr_q !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_ptr3: got %0d, required 0", dut.bank[3].u_bank.ptr_q);
      end
      r_avalid = '0;
      w_valid  = '0;
      rst      = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_single_read(input logic [15:0] addr);
      @(negedge clk);
      r_addr[0 +: AW] = addr;
      r_avalid        = 3'b001;
      #1;
      vectors++;
      if (r_aready !== 3'b001) begin
         miscompares++;
         $display("FAIL single_ready addr %h: got %b, required 001", addr, r_aready);
      end else begin
         exp_q.push_back('{0, model_rd(int'(addr)), cyc + L});
      end
      @(negedge clk);
      r_avalid = '0;
      wait_drain();
   endtask

   task automatic test_distinct_banks();
      @(negedge clk);
      for (int p = 0; p < R; p++) r_addr[p*AW +: AW] = 16'(16'h0110 + p);
      r_avalid = 3'b111;
      #1;
      vectors++;
      if (r_aready !== 3'b111) begin
         miscompares++;
         $display("FAIL distinct_ready: got %b, required 111", r_aready);
      end
      for (int p = 0; p < R; p++) begin
         if (r_aready[p]) exp_q.push_back('{p, model_rd(16'h0110 + p), cyc + L});
      end
      @(negedge clk);
      r_avalid = '0;
      wait_drain();
   endtask

   task automatic test_contention();
      logic [2:0] want [3];
      want[0] = 3'b001;
      want[1] = 3'b010;
      want[2] = 3'b100;
      do_reset();
      @(negedge clk);
      for (int p = 0; p < R; p++) r_addr[p*AW +: AW] = 16'(16'h0010 + 4 * p);
      r_avalid = 3'b111;
      for (int step = 0; step < R; step++) begin
         #1;
         vectors++;
         if (r_aready !== want[step]) begin
            miscompares++;
            $display("FAIL contention_grant step %0d: got %b, required %b", step, r_aready, want[step]);
         end
         exp_q.push_back('{step, model_rd(16'h0010 + 4 * step), cyc + L});
         @(negedge clk);
         r_avalid[step] = 1'b0;
      end
      wait_drain();
      vectors++;
      if (dut.bank[0].u_bank.ptr_q !== 3'd3) begin
         miscompares++;
         $display("FAIL contention_ptr: got %0d, required 3", dut.bank[0].u_bank.ptr_q);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      w_addr[0 +: AW] = 16'h0212;
      w_data[0 +: DW] = 16'hA012;
      w_valid         = 3'b001;
      #1;
      vectors++;
      if (w_ready !== 3'b001) begin
         miscompares++;
         $display("FAIL wr_ready: got %b, required 001", w_ready);
      end
      @(negedge clk);
      shadow[16'h0212]    = 16'hA012;
      w_valid             = '0;
      r_addr[2*AW +: AW]  = 16'h0212;
      r_avalid            = 3'b100;
      #1;
      vectors++;
      if (r_aready !== 3'b100) begin
         miscompares++;
         $display("FAIL wr_rd_ready: got %b, required 100", r_aready);
      end
      exp_q.push_back('{2, 16'hA012, cyc + L});
      @(negedge clk);
      r_avalid = '0;
      wait_drain();
   endtask

   task automatic test_same_cycle();
      do_reset();
      @(negedge clk);
      r_addr[0 +: AW]  = 16'h0020;
      r_avalid         = 3'b001;
      w_addr[AW +: AW] = 16'h0020;
      w_data[DW +: DW] = 16'hBEEF;
      w_valid          = 3'b010;
      #1;
      vectors++;
      if (r_aready !== 3'b001 || w_ready !== 3'b000) begin
         miscompares++;
         $display("FAIL same_cycle_first: got r %b w %b, required r 001 w 000", r_aready, w_ready);
      end
      exp_q.push_back('{0, model_rd(16'h0020), cyc + L});
      @(negedge clk);
      r_avalid = '0;
      #1;
      vectors++;
      if (w_ready !== 3'b010) begin
         miscompares++;
         $display("FAIL same_cycle_second: got w %b, required 010", w_ready);
      end
      @(negedge clk);
      shadow[16'h0020] = 16'hBEEF;
      w_valid          = '0;
      r_addr[AW +: AW] = 16'h0020;
      r_avalid         = 3'b010;
      #1;
      vectors++;
      if (r_aready !== 3'b010) begin
         miscompares++;
         $display("FAIL same_cycle_reread: got %b, required 010", r_aready);
      end
      exp_q.push_back('{1, 16'hBEEF, cyc + L});
      @(negedge clk);
      r_avalid = '0;
      wait_drain();
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      r_addr[0 +: AW] = 16'h0030;
      r_avalid        = 3'b001;
      #1;
      vectors++;
      if (r_aready !== 3'b001) begin
         miscompares++;
         $display("FAIL midrst_pre_ready: got %b, required 001", r_aready);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (r_aready !== 3'b000 || w_ready !== 3'b000) begin
         miscompares++;
         $display("FAIL midrst_ready: got r %b w %b, required 000 000", r_aready, w_ready);
      end
      @(negedge clk);
      vectors++;
      if (r_dvalid[0] !== 1'b0 || r_data[0 +: DW] !== 16'h0) begin
         miscompares++;
         $display("FAIL midrst_out: got dvalid %b data %h, required 0 0000", r_dvalid[0], r_data[0 +: DW]);
      end
      r_avalid = '0;
      rst      = 1'b0;
      @(negedge clk);
      vectors++;
      if (r_dvalid[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_late: got dvalid %b, required 0", r_dvalid[0]);
      end
      test_single_read(16'h0030);
   endtask

   task automatic test_back_to_back();
      int          ra [3];
      int          wa [3];
      logic [15:0] wd [3];
      bit          rp [3];
      bit          wp [3];
      int          rw [3];
      int          ww [3];
      for (int p = 0; p < R; p++) begin
         rp[p] = 0; wp[p] = 0; rw[p] = 0; ww[p] = 0; ra[p] = 0; wa[p] = 0; wd[p] = '0;
      end
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         for (int p = 0; p < R; p++) begin
            if (!rp[p] && $urandom_range(0, 1) == 1) begin
               rp[p] = 1; ra[p] = int'($urandom_range(0, 23)); rw[p] = 0;
            end
            if (!wp[p] && $urandom_range(0, 2) == 0) begin
               wp[p] = 1; wa[p] = int'($urandom_range(0, 23)); wd[p] = 16'($urandom); ww[p] = 0;
            end
            r_addr[p*AW +: AW] = 16'(ra[p]);
            r_avalid[p]        = rp[p];
            w_addr[p*AW +: AW] = 16'(wa[p]);
            w_data[p*DW +: DW] = wd[p];
            w_valid[p]         = wp[p];
         end
         #1;
         for (int p = 0; p < R; p++) begin
            vectors++;
            if (!rp[p] && r_aready[p] !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_rready_idle port %0d: got %b, required 0", p, r_aready[p]);
            end else if (rp[p] && r_aready[p] === 1'b1) begin
               if (rw[p] > 2 * R - 1) begin
                  miscompares++;
                  $display("FAIL b2b_rstarve port %0d: got wait %0d, required <= %0d", p, rw[p], 2 * R - 1);
               end
               exp_q.push_back('{p, model_rd(ra[p]), cyc + L});
               rp[p] = 0;
            end else if (rp[p]) begin
               rw[p]++;
            end
         end
         for (int p = 0; p < R; p++) begin
            vectors++;
            if (!wp[p] && w_ready[p] !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_wready_idle port %0d: got %b, required 0", p, w_ready[p]);
            end else if (wp[p] && w_ready[p] === 1'b1) begin
               if (ww[p] > 2 * R - 1) begin
                  miscompares++;
                  $display("FAIL b2b_wstarve port %0d: got wait %0d, required <= %0d", p, ww[p], 2 * R - 1);
               end
               shadow[wa[p]] = wd[p];
               wp[p] = 0;
            end else if (wp[p]) begin
               ww[p]++;
            end
         end
      end
      @(negedge clk);
      r_avalid = '0;
      w_valid  = '0;
      wait_drain();
   endtask

   initial begin
      rst      = 1'b1;
      r_addr   = '0;
      r_avalid = '0;
      w_addr   = '0;
      w_data   = '0;
      w_valid  = '0;
      test_reset();
      test_single_read(16'h0010);
      test_distinct_banks();
      test_contention();
      test_write_read();
      test_same_cycle();
      test_reset_mid_read();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
